// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority first-one picker
// Finds the first set request bit searching ptr, ptr+1, ... with wrap modulo N.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   localparam int SW = $clog2(N);
   localparam logic [SW:0] N_W = (SW+1)'(N);

   logic [SW:0]   sum;
   logic [SW-1:0] k;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      k     = '0;
      for (int i = 0; i < N; i++) begin
         // One extra bit keeps ptr+i exact so the wrap works for any N.
         sum = {1'b0, ptr} + (SW+1)'(i);
         if (sum >= N_W) sum = sum - N_W;
         k = sum[SW-1:0];
         if (!any && req[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter with registered N:1 data mux
// The granted index doubles as the mux select; the output stage is a single register.
module rr_mux_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         in_valid,
   input  logic [N*W-1:0]       in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_src,
   input  logic                 out_ready
);

   localparam int SW = $clog2(N);
   localparam logic [SW-1:0] LAST = SW'(N-1);

   logic [SW-1:0] ptr;
   logic [N-1:0]  grant;
   logic [SW-1:0] win_idx;
   logic          win_any;
   logic          can_load;
   logic [W-1:0]  words [N];

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign words[g] = in_data[g*W +: W];
   end

   rr_pick #(.N(N)) u_pick (
      .req   (in_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   assign can_load = !out_valid || out_ready;
   // rst gates the grant so no handshake is offered while reset is held.
   assign in_ready = (!rst && can_load) ? grant : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= '0;
      end else if (can_load) begin
         if (win_any) begin
            out_valid <= 1'b1;
            out_data  <= words[win_idx];
            out_src   <= win_idx;
            ptr       <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter (N=4, W=8)
module tb_rr_mux_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_src;
   logic           out_ready;

   int errors = 0;
   int checks = 0;

   logic [9:0] exp_q [$];
   logic [7:0] word_of [N];

   rr_mux_arbiter #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int src);
      exp_q.push_back({2'(src), word_of[src]});
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         logic [9:0] e;
         if (exp_q.size() == 0) begin
            check("unexpected_output", {22'd0, out_src, out_data}, 32'h3ff);
         end else begin
            e = exp_q.pop_front();
            check("sb_src", 32'(out_src), 32'(e[9:8]));
            check("sb_data", 32'(out_data), 32'(e[7:0]));
         end
      end
   end

   initial begin
      word_of[0] = 8'hC0;
      word_of[1] = 8'hB1;
      word_of[2] = 8'hA5;
      word_of[3] = 8'hD3;
      in_data    = {word_of[3], word_of[2], word_of[1], word_of[0]};
      rst        = 1'b1;
      in_valid   = 4'b1111;
      out_ready  = 1'b0;

      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_src", 32'(out_src), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      in_valid = 4'b0000;
      step();
      rst = 1'b0;

      // single requester
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      #1;
      check("single_in_ready", 32'(in_ready), 32'b0100);
      push(2);
      step();
      in_valid = 4'b0000;
      check("single_out_valid", 32'(out_valid), 1);
      check("single_out_src", 32'(out_src), 2);
      check("single_out_data", 32'(out_data), 32'hA5);
      step();

      // async reset pulse so the rotation starts from ptr=0
      rst = 1'b1;
      #1;
      rst = 1'b0;

      // all requesting: 0,1,2,3,0,1
      in_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("rot_in_ready%0d", i), 32'(in_ready), 32'(1 << (i % 4)));
         push(i % 4);
         step();
         check($sformatf("rot_out_valid%0d", i), 32'(out_valid), 1);
         check($sformatf("rot_out_src%0d", i), 32'(out_src), 32'(i % 4));
      end

      // backpressure: word from requester 1 held, ptr held at 2
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 0);
         check($sformatf("bp_out_src%0d", i), 32'(out_src), 1);
         check($sformatf("bp_out_data%0d", i), 32'(out_data), 32'hB1);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("resume_in_ready2", 32'(in_ready), 32'b0100);
      push(2);
      step();
      check("resume_out_src2", 32'(out_src), 2);
      #1;
      check("resume_in_ready3", 32'(in_ready), 32'b1000);
      push(3);
      step();
      check("resume_out_src3", 32'(out_src), 3);

      // wrap: after grant to 3, requesters 0 and 3
      in_valid = 4'b1001;
      #1;
      check("wrap_in_ready0", 32'(in_ready), 32'b0001);
      push(0);
      step();
      in_valid = 4'b1000;
      #1;
      check("wrap_in_ready3", 32'(in_ready), 32'b1000);
      push(3);
      step();
      in_valid = 4'b0000;
      step();
      step();
      check("idle_out_valid", 32'(out_valid), 0);

      // load a word from 1 (ptr -> 2), hold it, then reset between edges
      in_valid  = 4'b0010;
      out_ready = 1'b0;
      step();
      in_valid = 4'b1100;
      check("pre_rst_out_valid", 32'(out_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_out_valid", 32'(out_valid), 0);
      check("async_in_ready", 32'(in_ready), 0);
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'b0100);
      push(2);
      step();
      in_valid = 4'b1000;
      check("post_rst_out_src", 32'(out_src), 2);
      #1;
      check("post_rst_in_ready3", 32'(in_ready), 32'b1000);
      push(3);
      step();
      in_valid = 4'b0000;

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
      check("sb_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter with a registered N:1 data mux. It collects N valid/ready request streams and grants one per cycle in rotating priority. The winner's word goes onto a single registered valid/ready output. It sits directly upstream of the select-driven mux stages: its granted index is the mux select and its registered word is the mux output, so downstream logic gets a clean, fairly shared stream.

## Interface
- N, 4, number of requesters; N ≥ 2, need not be a power of two.
- W, 8, data width per requester.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately on assertion.
- in_valid  in  N  per-requester valid.
- in_data  in  N×W  packed data; requester k occupies bits [k·W +: W].
- in_ready  out  N  one-hot (or zero) grant; a transfer from k happens on a cycle where in_valid[k] && in_ready[k].
- out_valid  out  1  output register holds a word.
- out_data  out  W  registered winning word.
- out_src  out  $clog2(N)  index of the requester that supplied out_data.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.

## Operation
- State:
  - output register (out_valid, out_data, out_src);
  - rotating pointer ptr, range 0..N-1, which is the highest-priority index.
- can_load = !out_valid || out_ready.
- Winner: the first k with in_valid[k] high, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N).
- in_ready[k] = can_load && (k == winner) && any in_valid.
  - This is combinational from in_valid, out_valid and out_ready.
  - At most one bit is high.
- On a clock edge with can_load:
  - If a winner exists: out_data ← in_data[winner], out_src ← winner, out_valid ← 1, ptr ← (winner+1) mod N.
  - If no requester is valid: out_valid ← 0. out_data, out_src and ptr hold.
- On a clock edge with !can_load: all state holds, i.e. out_valid=1 and out_ready=0 (backpressure).
- ptr moves only on an accepted input transfer. A stalled cycle never changes priority.
- Requester rules: once in_valid[k] is high it stays high, with in_data[k] stable, until its transfer. The arbiter does not check this.
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0. in_ready=0 follows from out_valid=0 with no valid inputs.

## Timing
- Latency: one cycle from input transfer to out_valid/out_data.
- Throughput: one word per cycle while out_ready stays high.
- Simultaneous events: an output accept and a new input load on the same edge form a seamless handover, with no bubble.
- Fairness: with all N requesting continuously and no backpressure, each requester is granted exactly once in every N consecutive grants.
- Wrap-around: after a grant to N-1, ptr=0.
- Reset mid-operation:
  - Asserting rst drops out_valid and in_ready to 0 asynchronously, without waiting for a clock edge.
  - Any held word is discarded.
  - The first grant after release follows ptr=0.
- No combinational path from in_data to any output.

## Structure
- No shared package is needed. N and W are module parameters, and the source index width is derived locally as $clog2(N).
- One combinational sub-module, rr_pick:
  - Inputs: request vector (N) and ptr.
  - Outputs: one-hot grant and its binary index.
  - Top level adds can_load gating, the data mux indexed by the binary winner, the output register and the ptr update.

## Test plan
(N=4, W=8.)
- Reset:
  - Stimulus: rst=1 with all in_valid=1.
  - Required: out_valid=0, out_data=0, out_src=0, in_ready=0000 without any clock edge.
- Single requester:
  - Stimulus: in_valid=0100, in_data[2]=8'hA5, out_ready=1.
  - Required: in_ready=0100 that cycle; next cycle out_valid=1, out_data=A5, out_src=2.
- All requesting, out_ready=1, from reset:
  - Required: out_src sequence 0,1,2,3,0,1 on consecutive cycles, with out_valid constantly 1.
- Backpressure:
  - Stimulus: out_valid=1, out_ready=0 for 3 cycles while all request.
  - Required: in_ready=0000; out_data, out_src and ptr hold. After out_ready=1, grants resume from the held ptr with no skipped requester.
- Wrap:
  - Stimulus: last grant to 3, then in_valid=1001.
  - Required: grant to 0, then to 3.
- Async reset mid-stream:
  - Stimulus: assert rst between edges while out_valid=1 and ptr=2.
  - Required: out_valid drops immediately. After release with in_valid=1100, the first grant goes to 2.
